// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
// Contents:
//   state_t        loader FSM states
//   BYTES_PER_WORD stream bytes packed into one instruction word
//   BYTE_IDX_W     width of the byte-position counter inside a word
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs big-endian stream bytes into 32-bit words
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_clear      drop any partial word and restart at byte 0
//   i_valid      a byte is being consumed this cycle
//   i_byte       the byte being consumed
//   i_last       consumed byte ends the image; flush a partial word
//   o_word       word as it stands including the current byte (combinational)
//   o_word_valid o_word is complete and must be written this cycle
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [31:0]           r_acc;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic [31:0]           w_placed;
    logic                  w_word_end;

    // Lanes fill from the MSB down. Unfilled lanes of r_acc are always zero,
    // so a flush on i_last is left-justified with zero padding for free.
    assign w_placed     = {i_byte, 24'd0} >> {r_byte_idx, 3'b000};
    assign w_word_end   = (r_byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign o_word       = r_acc | w_placed;
    assign o_word_valid = i_valid && (w_word_end || i_last);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc      <= 32'd0;
            r_byte_idx <= '0;
        end else if (i_valid) begin
            if (o_word_valid) begin
                r_acc      <= 32'd0;
                r_byte_idx <= '0;
            end else begin
                r_acc      <= o_word;
                r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction-memory loader that holds the CPU in reset
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds o_checksum.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_start          one-cycle pulse, begins a load from IDLE, DONE or FAIL
//   i_in_valid       stream byte valid
//   i_in_data        stream byte, first byte of a word lands in [31:24]
//   i_in_last        marks final byte of the image
//   o_in_ready       loader accepts a byte
//   o_wr_en          imem write strobe, one cycle per word
//   o_wr_addr        imem word address
//   o_wr_data        packed word
//   o_cpu_rst        CPU reset, low only in DONE
//   o_done           image loaded
//   o_err            image exceeded capacity
//   o_word_count     words written in this load
//   o_checksum       (macro only) mod-2^32 sum of written words
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_last,
    output logic              o_in_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       o_checksum
`endif
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_in_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_word_count;

    logic                w_accept;
    logic                w_full;
    logic                w_pack_valid;
    logic                w_overflow;
    logic                w_start_go;
    logic [31:0]         w_word;
    logic                w_write;
    logic                w_in_ready_nxt;
    logic                w_done_nxt;
    logic                w_cpu_rst_nxt;
    logic                w_err_nxt;

    // in_ready lags the state by a cycle, so the state check keeps the loader
    // from consuming a byte in the first cycle of DONE/FAIL.
    assign w_accept     = i_in_valid && r_in_ready &&
                          ((r_state == ST_LOAD) || (r_state == ST_DRAIN));
    // Top bit of word_count set means every address has been written.
    assign w_full       = r_word_count[ADDR_W];
    assign w_pack_valid = w_accept && (r_state == ST_LOAD) && !w_full;
    assign w_overflow   = w_accept && (r_state == ST_LOAD) && w_full;
    assign w_start_go   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                      (r_state == ST_FAIL));

    imem_word_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_start_go),
        .i_valid      (w_pack_valid),
        .i_byte       (i_in_data),
        .i_last       (i_in_last),
        .o_word       (w_word),
        .o_word_valid (w_write)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (i_start) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_overflow) begin
                    w_next_state = i_in_last ? ST_FAIL : ST_DRAIN;
                end else if (w_pack_valid && i_in_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (w_accept && i_in_last) begin
                    w_next_state = ST_FAIL;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered status outputs. done and
    // cpu_rst follow the current state, so they move one cycle after DONE is
    // entered and the final write has already been presented.
    always_comb begin
        w_in_ready_nxt = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
        w_done_nxt     = (r_state == ST_DONE) && !w_start_go;
        w_cpu_rst_nxt  = !w_done_nxt;
        w_err_nxt      = w_start_go ? 1'b0 : (r_err || w_overflow);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 32'd0;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_done     <= w_done_nxt;
            r_cpu_rst  <= w_cpu_rst_nxt;
            r_err      <= w_err_nxt;
            r_wr_en    <= w_write;
            if (w_write) begin
                r_wr_addr <= r_word_count[ADDR_W-1:0];
                r_wr_data <= w_word;
            end
            if (w_start_go) begin
                r_word_count <= '0;
            end else if (w_write) begin
                r_word_count <= r_word_count + (ADDR_W + 1)'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_go) begin
            r_checksum <= 32'd0;
        end else if (w_write) begin
            r_checksum <= r_checksum + w_word;
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign o_in_ready   = r_in_ready;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_cpu_rst    = r_cpu_rst;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;

    logic        in_ready, wr_en, cpu_rst, done, err;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [10:0] word_count;

    logic        b_in_ready, b_wr_en, b_cpu_rst, b_done, b_err;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [2:0]  b_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum, b_checksum;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  stim [0:31];
    logic [31:0] wd[$];
    int          wa[$];
    int          wcyc[$];
    logic        wcr[$];
    logic [31:0] bwd[$];
    int          bwa[$];

    imem_loader #(.ADDR_W(10)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
        .i_in_data(in_data), .i_in_last(in_last), .o_in_ready(in_ready),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_cpu_rst(cpu_rst), .o_done(done), .o_err(err), .o_word_count(word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .o_checksum(checksum)
`endif
    );

    imem_loader #(.ADDR_W(2)) u_small (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
        .i_in_data(in_data), .i_in_last(in_last), .o_in_ready(b_in_ready),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
        .o_cpu_rst(b_cpu_rst), .o_done(b_done), .o_err(b_err), .o_word_count(b_word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .o_checksum(b_checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wd.push_back(wr_data);
            wa.push_back(int'(wr_addr));
            wcyc.push_back(cyc);
            wcr.push_back(cpu_rst);
        end
        if (b_wr_en) begin
            bwd.push_back(b_wr_data);
            bwa.push_back(int'(b_wr_addr));
        end
    end

    task automatic clear_log();
        wd.delete(); wa.delete(); wcyc.delete(); wcr.delete();
        bwd.delete(); bwa.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int n, input int gap, input bit with_last);
        int t;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = with_last && (i == n - 1);
            t = 0;
            while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
            if (t >= 20) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: byte %0d in_ready stayed %b, required 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        n_tests++; if (wr_addr !== 10'd0) begin n_fail++; $display("FAIL rst_wr_addr: got %h want 0", wr_addr); end
        n_tests++; if (wr_data !== 32'd0) begin n_fail++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
        n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        n_tests++; if (word_count !== 11'd0) begin n_fail++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_two_words();
        stim[0] = 8'h20; stim[1] = 8'h08; stim[2] = 8'h00; stim[3] = 8'h05;
        stim[4] = 8'hAC; stim[5] = 8'h08; stim[6] = 8'h00; stim[7] = 8'h50;
        clear_log();
        do_start();
        send(8, 0, 1'b1);
        // final write cycle: still in reset, not done
        n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL tw_last_wr_en: got %b want 1", wr_en); end
        n_tests++; if (done !== 1'b0 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL tw_write_cycle: done=%b cpu_rst=%b want 0/1", done, cpu_rst); end
        n_tests++; if (word_count !== 11'd2) begin n_fail++; $display("FAIL tw_wc_on_write: got %0d want 2", word_count); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL tw_after_write: done=%b cpu_rst=%b want 1/0", done, cpu_rst); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL tw_wr_en_drop: got %b want 0", wr_en); end
        settle();
        n_tests++; if (wd.size() != 2) begin n_fail++; $display("FAIL tw_nwrites: got %0d want 2", wd.size()); end
        if (wd.size() == 2) begin
            n_tests++; if (wd[0] !== 32'h20080005 || wa[0] != 0) begin n_fail++; $display("FAIL tw_word0: got %h@%0d want 20080005@0", wd[0], wa[0]); end
            n_tests++; if (wd[1] !== 32'hAC080050 || wa[1] != 1) begin n_fail++; $display("FAIL tw_word1: got %h@%0d want ac080050@1", wd[1], wa[1]); end
            n_tests++; if (wcyc[1] - wcyc[0] != 4) begin n_fail++; $display("FAIL tw_spacing: got %0d want 4", wcyc[1] - wcyc[0]); end
            n_tests++; if (wcr[1] !== 1'b1) begin n_fail++; $display("FAIL tw_cpu_rst_at_write: got %b want 1", wcr[1]); end
        end
        n_tests++; if (in_ready !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL tw_idle_flags: in_ready=%b err=%b want 0/0", in_ready, err); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_tests++; if (checksum !== 32'hCC100055) begin n_fail++; $display("FAIL tw_checksum: got %h want cc100055", checksum); end
`endif
    endtask

    task automatic test_pad();
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
        stim[3] = 8'h44; stim[4] = 8'h55; stim[5] = 8'h66;
        clear_log();
        do_start();
        // restart out of DONE puts the CPU back in reset immediately
        n_tests++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL pad_restart: cpu_rst=%b done=%b want 1/0", cpu_rst, done); end
        n_tests++; if (word_count !== 11'd0) begin n_fail++; $display("FAIL pad_wc_clear: got %0d want 0", word_count); end
        send(6, 0, 1'b1);
        settle();
        n_tests++; if (wd.size() != 2) begin n_fail++; $display("FAIL pad_nwrites: got %0d want 2", wd.size()); end
        if (wd.size() == 2) begin
            n_tests++; if (wd[0] !== 32'h11223344 || wa[0] != 0) begin n_fail++; $display("FAIL pad_word0: got %h@%0d want 11223344@0", wd[0], wa[0]); end
            n_tests++; if (wd[1] !== 32'h55660000 || wa[1] != 1) begin n_fail++; $display("FAIL pad_word1: got %h@%0d want 55660000@1", wd[1], wa[1]); end
        end
        n_tests++; if (word_count !== 11'd2 || done !== 1'b1) begin n_fail++; $display("FAIL pad_final: wc=%0d done=%b want 2/1", word_count, done); end
        // single byte image
        stim[0] = 8'hAB;
        clear_log();
        do_start();
        send(1, 0, 1'b1);
        settle();
        n_tests++; if (wd.size() != 1) begin n_fail++; $display("FAIL pad1_nwrites: got %0d want 1", wd.size()); end
        if (wd.size() == 1) begin
            n_tests++; if (wd[0] !== 32'hAB000000 || wa[0] != 0) begin n_fail++; $display("FAIL pad1_word: got %h@%0d want ab000000@0", wd[0], wa[0]); end
        end
        n_tests++; if (word_count !== 11'd1) begin n_fail++; $display("FAIL pad1_wc: got %0d want 1", word_count); end
    endtask

    task automatic test_gaps();
        stim[0] = 8'h20; stim[1] = 8'h08; stim[2] = 8'h00; stim[3] = 8'h05;
        stim[4] = 8'hAC; stim[5] = 8'h08; stim[6] = 8'h00; stim[7] = 8'h50;
        clear_log();
        do_start();
        send(8, 1, 1'b1);
        settle();
        n_tests++; if (wd.size() != 2) begin n_fail++; $display("FAIL gap_nwrites: got %0d want 2", wd.size()); end
        if (wd.size() == 2) begin
            n_tests++; if (wd[0] !== 32'h20080005 || wd[1] !== 32'hAC080050) begin n_fail++; $display("FAIL gap_words: got %h %h want 20080005 ac080050", wd[0], wd[1]); end
            n_tests++; if (wcyc[1] - wcyc[0] != 8) begin n_fail++; $display("FAIL gap_spacing: got %0d want 8", wcyc[1] - wcyc[0]); end
        end
        n_tests++; if (done !== 1'b1 || word_count !== 11'd2) begin n_fail++; $display("FAIL gap_final: done=%b wc=%0d want 1/2", done, word_count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) stim[i] = 8'(i + 1);
        clear_log();
        do_start();
        send(20, 0, 1'b1);
        settle();
        n_tests++; if (bwd.size() != 4) begin n_fail++; $display("FAIL ovf_nwrites: got %0d want 4", bwd.size()); end
        if (bwd.size() == 4) begin
            n_tests++; if (bwd[3] !== 32'h0D0E0F10 || bwa[3] != 3) begin n_fail++; $display("FAIL ovf_word3: got %h@%0d want 0d0e0f10@3", bwd[3], bwa[3]); end
        end
        n_tests++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", b_err); end
        n_tests++; if (b_cpu_rst !== 1'b1 || b_done !== 1'b0) begin n_fail++; $display("FAIL ovf_flags: cpu_rst=%b done=%b want 1/0", b_cpu_rst, b_done); end
        n_tests++; if (b_word_count !== 3'd4 || b_in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_wc_ready: wc=%0d in_ready=%b want 4/0", b_word_count, b_in_ready); end
        // large instance takes the same 20 bytes as five full words
        n_tests++; if (wd.size() != 5 || done !== 1'b1) begin n_fail++; $display("FAIL ovf_big: nwrites=%0d done=%b want 5/1", wd.size(), done); end
        // restart out of FAIL clears err; exact fill is not an overflow
        clear_log();
        do_start();
        n_tests++; if (b_err !== 1'b0 || b_cpu_rst !== 1'b1) begin n_fail++; $display("FAIL fail_restart: err=%b cpu_rst=%b want 0/1", b_err, b_cpu_rst); end
        send(16, 0, 1'b1);
        settle();
        n_tests++; if (bwd.size() != 4 || b_done !== 1'b1 || b_err !== 1'b0) begin n_fail++; $display("FAIL fill_exact: nwrites=%0d done=%b err=%b want 4/1/0", bwd.size(), b_done, b_err); end
    endtask

    task automatic test_reset_midload();
        stim[0] = 8'h77; stim[1] = 8'h88; stim[2] = 8'h99;
        clear_log();
        do_start();
        send(3, 0, 1'b0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_tests++; if (in_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || word_count !== 11'd0) begin
            n_fail++; $display("FAIL mid_rst_state: in_ready=%b cpu_rst=%b done=%b wc=%0d want 0/1/0/0", in_ready, cpu_rst, done, word_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        stim[0] = 8'hDE; stim[1] = 8'hAD; stim[2] = 8'hBE; stim[3] = 8'hEF;
        clear_log();
        do_start();
        send(4, 0, 1'b1);
        settle();
        n_tests++; if (wd.size() != 1) begin n_fail++; $display("FAIL mid_nwrites: got %0d want 1", wd.size()); end
        if (wd.size() == 1) begin
            n_tests++; if (wd[0] !== 32'hDEADBEEF || wa[0] != 0) begin n_fail++; $display("FAIL mid_word: got %h@%0d want deadbeef@0", wd[0], wa[0]); end
        end
        n_tests++; if (word_count !== 11'd1 || done !== 1'b1) begin n_fail++; $display("FAIL mid_final: wc=%0d done=%b want 1/1", word_count, done); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        stim[0] = 8'h00; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h01;
        stim[4] = 8'hFF; stim[5] = 8'hFF; stim[6] = 8'hFF; stim[7] = 8'hFF;
        clear_log();
        do_start();
        send(4, 0, 1'b0);
        @(posedge clk); #1;
        n_tests++; if (checksum !== 32'h00000001) begin n_fail++; $display("FAIL cks_partial: got %h want 00000001", checksum); end
        for (int i = 0; i < 4; i++) stim[i] = stim[i + 4];
        send(4, 0, 1'b1);
        settle();
        n_tests++; if (checksum !== 32'h00000000 || done !== 1'b1) begin n_fail++; $display("FAIL cks_wrap: got %h done=%b want 00000000/1", checksum, done); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_pad();
        test_gaps();
        test_overflow();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware instruction-memory loader for the single-cycle CPU. It accepts a byte stream, packs big-endian bytes into 32-bit words, and writes them to sequential word addresses of instruction memory. While the load is in progress it holds the CPU in reset, and it releases reset once the image is complete. It sits between an external byte source (host link or boot ROM streamer) and the instruction memory's write port, and replaces file-based image loading on hardware.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity is 2^ADDR_W words
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new load from IDLE, DONE or FAIL
- in_valid  in  1  byte-stream valid
- in_data  in  8  stream byte; first byte of each word is bits [31:24]
- in_last  in  1  qualifies the final byte of the image; sampled with in_valid
- in_ready  out  1  loader can accept a byte
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address (0 = text base)
- wr_data  out  32  packed word
- cpu_rst  out  1  held high except in DONE
- done  out  1  image loaded successfully
- err  out  1  image exceeded capacity
- word_count  out  ADDR_W+1  words written in the current load

## Operation
- States: IDLE, LOAD, DRAIN, DONE, FAIL.
- IDLE: in_ready=0. On start, go to LOAD and clear byte_idx, word_count, done and err.
- LOAD: in_ready=1. A byte is accepted when in_valid and in_ready are both high.
  - The byte is shifted into the packer and byte_idx increments mod 4.
  - On the 4th byte, the word is written at wr_addr=word_count[ADDR_W-1:0], then word_count increments.
  - If in_last arrives with 1–3 bytes accumulated, the word is left-justified with the low bytes zero-padded and written. in_last on the 4th byte causes exactly one write, with no extra padded word.
  - After in_last: go to DONE.
- Overflow: a byte accepted in LOAD while word_count == 2^ADDR_W causes no write and sets err.
  - If that byte carries in_last, go to FAIL.
  - Otherwise go to DRAIN.
- DRAIN: in_ready=1; bytes are discarded until in_last is accepted, then go to FAIL.
- DONE: done=1, cpu_rst=0, in_ready=0. start re-enters LOAD and sets cpu_rst=1 the next cycle.
- FAIL: err=1, cpu_rst=1, in_ready=0. start re-enters LOAD.
- start is ignored in LOAD and DRAIN.
- rst mid-load returns all state to reset values. Words already written to memory are not erased.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, done=0, err=0, word_count=0, state=IDLE.
- All outputs are registered.
- wr_en is high for exactly the cycle after the completing byte is accepted, with wr_addr and wr_data valid in that same cycle.
- Throughput is one byte per cycle with no bubbles. Back-to-back words produce wr_en every 4th cycle.
- word_count updates in the same cycle wr_en is high.
- For a final write, the state enters DONE in the cycle of that write. done rises and cpu_rst falls in the following cycle, so the CPU never leaves reset before the last write completes.
- in_ready changes on the cycle after a state transition. A byte presented on the in_last cycle is the last byte the loader consumes.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - Adds output checksum[31:0], the mod-2^32 sum of every wr_data written in the current load.
  - Reset value 0; cleared on start; updates with wr_en.
  - Valid when done=1.
- Not defined: the port and adder are absent, and behaviour is otherwise identical.

## Structure
- imem_loader_pkg holds the state enum (IDLE, LOAD, DRAIN, DONE, FAIL) and the bytes-per-word localparam (4).
- Sub-module imem_word_packer holds the shift register, byte_idx and the zero-pad on flush. Its outputs are word and word_valid. The FSM and address counter stay in imem_loader.

## Test plan
- Start, then 8 bytes 20 08 00 05 AC 08 00 50, last on the 8th byte → writes 0x20080005@0 and 0xAC080050@1; word_count=2; done=1; cpu_rst falls after the second wr_en.
- 6 bytes 11 22 33 44 55 66, last on the 6th → second write 0x55660000@1; word_count=2.
- ADDR_W=2, 20 bytes with last on the 20th → 4 writes; bytes 17–20 drained with no wr_en; err=1; cpu_rst stays 1; done=0.
- in_valid toggling every other cycle across 8 bytes → same two words; wr_en only on completions.
- rst asserted after 3 bytes, then start and 4 bytes DE AD BE EF with last → single write 0xDEADBEEF@0; no stale bytes appear.
- With IMEM_LOADER_CHECKSUM_EN, words 0x00000001 and 0xFFFFFFFF → checksum=0x00000000 at done.
